// File: rtl/systolic_io_ctrl_if.sv
// Job, serial-stream and bank-enable signals between the host side and the
// systolic I/O sequencing controller.
interface systolic_io_ctrl_if #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 16
);
  localparam int IN_LANES = SIZE * 8 / WIDTH;

  logic                start;
  logic [IN_LANES-1:0] in_mask;
  logic [SIZE-1:0]     out_mask;
  logic                abort;
  logic                src_valid;
  logic                src_ready;
  logic [IN_LANES-1:0] in_en;
  logic                array_start;
  logic                array_done;
  logic [SIZE-1:0]     out_en;
  logic                dst_valid;
  logic                dst_last;
  logic                busy;
  logic                done;

  modport master (
    output start, in_mask, out_mask, abort, src_valid, array_done,
    input  src_ready, in_en, array_start, out_en, dst_valid, dst_last, busy, done
  );

  modport slave (
    input  start, in_mask, out_mask, abort, src_valid, array_done,
    output src_ready, in_en, array_start, out_en, dst_valid, dst_last, busy, done
  );
endinterface

// File: rtl/systolic_io_ctrl.sv
// Per-job sequencer for the systolic array I/O banks: serial load of the input
// SIPO bank, compute trigger, parallel load and drain of the output PISO bank.
module systolic_io_ctrl #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  systolic_io_ctrl_if.slave bus
);
  localparam int IN_LANES = SIZE * 8 / WIDTH;
  localparam int CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    ARM,
    COMPUTE,
    LOAD,
    SHIFT_OUT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IN_LANES-1:0] in_mask_q, in_mask_d;
  logic [SIZE-1:0]     out_mask_q, out_mask_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      in_mask_q  <= '0;
      out_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      in_mask_q  <= in_mask_d;
      out_mask_q <= out_mask_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    in_mask_d  = in_mask_q;
    out_mask_d = out_mask_q;

    if (bus.abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d    = SHIFT_IN;
            bit_cnt_d  = '0;
            in_mask_d  = bus.in_mask;
            out_mask_d = bus.out_mask;
          end
        end
        SHIFT_IN: begin
          if (bus.src_valid) begin
            if (bit_cnt_q == CNT_LAST) begin
              state_d   = ARM;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end
        end
        ARM:     state_d = COMPUTE;
        COMPUTE: if (bus.array_done) state_d = LOAD;
        LOAD: begin
          state_d   = SHIFT_OUT;
          bit_cnt_d = '0;
        end
        SHIFT_OUT: begin
          if (bit_cnt_q == CNT_LAST) begin
            state_d   = DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  logic                src_ready;
  logic [IN_LANES-1:0] in_en;
  logic                array_start;
  logic [SIZE-1:0]     out_en;
  logic                dst_valid;
  logic                dst_last;
  logic                busy;
  logic                done;

  // Outputs depend only on registered state; in_en alone also gates on src_valid.
  always_comb begin
    src_ready   = 1'b0;
    in_en       = '0;
    array_start = 1'b0;
    out_en      = '0;
    dst_valid   = 1'b0;
    dst_last    = 1'b0;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    case (state_q)
      SHIFT_IN: begin
        src_ready = 1'b1;
        if (bus.src_valid) in_en = in_mask_q;
      end
      ARM:  array_start = 1'b1;
      LOAD: out_en = out_mask_q;
      SHIFT_OUT: begin
        dst_valid = 1'b1;
        dst_last  = (bit_cnt_q == CNT_LAST);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bus.src_ready   = src_ready;
  assign bus.in_en       = in_en;
  assign bus.array_start = array_start;
  assign bus.out_en      = out_en;
  assign bus.dst_valid   = dst_valid;
  assign bus.dst_last    = dst_last;
  assign bus.busy        = busy;
  assign bus.done        = done;
endmodule
